axi_read_arbiter_rr: RTL and testbench

//  Parametrised N-master AXI read arbiter with round-robin fairness, replacing fixed-priority read muxing.

---
 rtl/axi_arb_pkg.sv | 13 +
 rtl/rr_picker.sv | 30 +++
 rtl/axi_read_arbiter_rr.sv | 148 ++++++++++++++
 tb/tb_axi_read_arbiter_rr.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the round-robin AXI read arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_e;

  localparam int LEN_WIDTH   = 4;
  localparam int MAX_MASTERS = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping at N-1 -> 0.
module rr_picker
  import axi_arb_pkg::*;
#(
  parameter int N  = 9,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    return IW'((int'(base) + off) % N);
  endfunction

  // Scan from the farthest offset down so the nearest requester after 'last' is the one kept.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[wrap_idx(last, k)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = wrap_idx(last, k);
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter_rr.sv
// N-master round-robin AXI read arbiter, one burst in flight, ARID = granted master index.
// Define ARB_PERF_EN to add per-master saturating grant/wait counters and their output ports.
module axi_read_arbiter_rr
  import axi_arb_pkg::*;
#(
  parameter int READ_MASTERS = 9,
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [READ_MASTERS-1:0]          m_arvalid,
  output logic [READ_MASTERS-1:0]          m_arready,
  input  logic [READ_MASTERS*LEN_WIDTH-1:0] m_arlen,
  input  logic [READ_MASTERS*ADDR_WIDTH-1:0] m_araddr,
  output logic [READ_MASTERS-1:0]          m_rvalid,
  input  logic [READ_MASTERS-1:0]          m_rready,
  output logic                             m_rlast,
  output logic [DATA_WIDTH-1:0]            m_rdata,
  output logic                             ARVALID,
  input  logic                             ARREADY,
  output logic [ID_WIDTH-1:0]              ARID,
  output logic [LEN_WIDTH-1:0]             ARLEN,
  output logic [ADDR_WIDTH-1:0]            ARADDR,
  input  logic                             RVALID,
  output logic                             RREADY,
  input  logic                             RLAST,
  input  logic [ID_WIDTH-1:0]              RID,
  input  logic [DATA_WIDTH-1:0]            RDATA,
  output logic                             err
`ifdef ARB_PERF_EN
  ,
  output logic [READ_MASTERS*32-1:0]       perf_grant_cnt,
  output logic [READ_MASTERS*32-1:0]       perf_wait_cnt
`endif
);

  localparam int IW = idx_width(READ_MASTERS);

  arb_state_e            state_reg, state_next;
  logic [IW-1:0]         last_grant_reg;
  logic [IW-1:0]         gnt_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LEN_WIDTH-1:0]  beat_cnt_reg;
  logic                  err_reg;

  logic                  pick_valid;
  logic [IW-1:0]         pick_idx;
  logic                  rid_match;
  logic                  r_hs;

  rr_picker #(.N(READ_MASTERS), .IW(IW)) u_picker (
    .req       (m_arvalid),
    .last      (last_grant_reg),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  assign rid_match = (RID == ID_WIDTH'(gnt_reg));
  assign r_hs      = (state_reg == DATA) && RVALID && rid_match && m_rready[gnt_reg];

  assign ARID    = ID_WIDTH'(gnt_reg);
  assign ARLEN   = len_reg;
  assign ARADDR  = addr_reg;
  assign err     = err_reg;
  assign m_rlast = RLAST;
  assign m_rdata = RDATA;

  always_comb begin
    state_next = state_reg;
    m_arready  = '0;
    m_rvalid   = '0;
    RREADY     = 1'b0;
    ARVALID    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          m_arready[pick_idx] = 1'b1;
          state_next          = ADDR;
        end
      end
      ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_next = DATA;
      end
      DATA: begin
        // Beats carrying a foreign RID are neither routed nor accepted.
        if (RVALID && rid_match) begin
          m_rvalid[gnt_reg] = 1'b1;
          RREADY            = m_rready[gnt_reg];
          if (m_rready[gnt_reg] && RLAST) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= IW'(READ_MASTERS - 1);
      gnt_reg        <= '0;
      len_reg        <= '0;
      addr_reg       <= '0;
      beat_cnt_reg   <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && pick_valid) begin
        gnt_reg  <= pick_idx;
        len_reg  <= m_arlen[int'(pick_idx)*LEN_WIDTH +: LEN_WIDTH];
        addr_reg <= m_araddr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (state_reg == ADDR && ARREADY) beat_cnt_reg <= '0;
      if (r_hs) begin
        beat_cnt_reg <= beat_cnt_reg + 1'b1;
        if (RLAST != (beat_cnt_reg == len_reg)) err_reg <= 1'b1;
        if (RLAST) last_grant_reg <= gnt_reg;
      end
      if (state_reg == DATA && RVALID && !rid_match) err_reg <= 1'b1;
    end
  end

`ifdef ARB_PERF_EN
  for (genvar gi = 0; gi < READ_MASTERS; gi++) begin : g_perf
    logic [31:0] grant_cnt_reg;
    logic [31:0] wait_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        grant_cnt_reg <= '0;
        wait_cnt_reg  <= '0;
      end else begin
        if (m_arvalid[gi] && m_arready[gi] && grant_cnt_reg != '1)
          grant_cnt_reg <= grant_cnt_reg + 1'b1;
        if (m_arvalid[gi] && !m_arready[gi] && wait_cnt_reg != '1)
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
    end

    assign perf_grant_cnt[gi*32 +: 32] = grant_cnt_reg;
    assign perf_wait_cnt[gi*32 +: 32]  = wait_cnt_reg;
  end
`endif

endmodule

// File: tb/tb_axi_read_arbiter_rr.sv
// Directed self-checking bench for axi_read_arbiter_rr (perf counters checked when ARB_PERF_EN is defined).
module tb_axi_read_arbiter_rr;

  localparam int N  = 9;
  localparam int AW = 26;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N*4-1:0]  m_arlen;
  logic [N*AW-1:0] m_araddr;
  logic            m_rlast;
  logic [DW-1:0]   m_rdata;
  logic            ARVALID, ARREADY;
  logic [3:0]      ARID, ARLEN;
  logic [AW-1:0]   ARADDR;
  logic            RVALID, RREADY, RLAST;
  logic [3:0]      RID;
  logic [DW-1:0]   RDATA;
  logic            err;
`ifdef ARB_PERF_EN
  logic [N*32-1:0] perf_grant_cnt, perf_wait_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_read_arbiter_rr #(.READ_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arlen(m_arlen), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast), .m_rdata(m_rdata),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
    .err(err)
`ifdef ARB_PERF_EN
    , .perf_grant_cnt(perf_grant_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    m_arvalid = '0; m_rready = '0; ARREADY = 1'b0;
    RVALID = 1'b0; RLAST = 1'b0; RID = '0; RDATA = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Request from master m, check the accept and the AR channel in ADDR; leaves ARREADY=1.
  task automatic issue_req(input int m, input logic [3:0] len, input logic [AW-1:0] addr);
    @(posedge clk); #1;
    m_arvalid[m] = 1'b1;
    m_arlen[m*4 +: 4] = len;
    m_araddr[m*AW +: AW] = addr;
    ARREADY = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_arready !== N'(1 << m)) begin
      n_fail++; $display("FAIL accept_m%0d: m_arready=%b expected %b", m, m_arready, N'(1 << m));
    end
    @(posedge clk); #1;
    m_arvalid[m] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ARVALID !== 1'b1 || ARID !== 4'(m) || ARLEN !== len || ARADDR !== addr) begin
      n_fail++;
      $display("FAIL ar_chan_m%0d: ARVALID=%b ARID=%0d ARLEN=%0d ARADDR=%h expected 1/%0d/%0d/%h",
               m, ARVALID, ARID, ARLEN, ARADDR, m, len, addr);
    end
  endtask

  // Deliver len+1 beats to master m with RLAST on the final one.
  task automatic run_beats(input int m, input int len);
    for (int b = 0; b <= len; b++) begin
      @(posedge clk); #1;
      RVALID = 1'b1; RID = 4'(m); RLAST = (b == len);
      RDATA = {8'hA5, 8'(m), 8'(len), 8'(b)};
      m_rready[m] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (m_rvalid !== N'(1 << m) || RREADY !== 1'b1 || m_rdata !== RDATA || m_rlast !== (b == len)) begin
        n_fail++;
        $display("FAIL beat_m%0d_b%0d: m_rvalid=%b RREADY=%b m_rdata=%h m_rlast=%b expected %b/1/%h/%b",
                 m, b, m_rvalid, RREADY, m_rdata, m_rlast, N'(1 << m), RDATA, (b == len));
      end
    end
    @(posedge clk); #1;
    RVALID = 1'b0; RLAST = 1'b0; m_rready = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    m_arlen = '0; m_araddr = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (m_arready !== '0 || m_rvalid !== '0 || ARVALID !== 1'b0 || RREADY !== 1'b0 ||
        ARID !== 4'd0 || ARLEN !== 4'd0 || ARADDR !== '0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: m_arready=%b m_rvalid=%b ARVALID=%b RREADY=%b ARID=%0d ARLEN=%0d ARADDR=%h err=%b expected all 0",
               m_arready, m_rvalid, ARVALID, RREADY, ARID, ARLEN, ARADDR, err);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single_master();
    for (int r = 0; r < 3; r++) begin
      issue_req(3, 4'd3, AW'(26'h0100 + r * 16));
      run_beats(3, 3);
      $display("single_master burst %0d complete", r);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || ARVALID !== 1'b0) begin
      n_fail++; $display("FAIL single_master_end: err=%b ARVALID=%b expected 0/0", err, ARVALID);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < N; i++) begin
      m_arlen[i*4 +: 4] = 4'd0;
      m_araddr[i*AW +: AW] = AW'(i * 64 + 4);
    end
    m_arvalid = '1; m_rready = '1; ARREADY = 1'b1;
    for (int k = 0; k <= N; k++) begin
      int g;
      g = k % N;
      @(negedge clk);
      n_checks++;
      if (m_arready !== N'(1 << g)) begin
        n_fail++; $display("FAIL rr_grant_%0d: m_arready=%b expected %b", k, m_arready, N'(1 << g));
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (ARVALID !== 1'b1 || ARID !== 4'(g) || ARADDR !== AW'(g * 64 + 4) || m_arready !== '0) begin
        n_fail++;
        $display("FAIL rr_addr_%0d: ARVALID=%b ARID=%0d ARADDR=%h m_arready=%b expected 1/%0d/%h/0",
                 k, ARVALID, ARID, ARADDR, m_arready, g, AW'(g * 64 + 4));
      end
      @(posedge clk); #1;
      RVALID = 1'b1; RID = 4'(g); RLAST = 1'b1; RDATA = DW'(k);
      @(negedge clk);
      n_checks++;
      if (m_rvalid !== N'(1 << g)) begin
        n_fail++; $display("FAIL rr_data_%0d: m_rvalid=%b expected %b", k, m_rvalid, N'(1 << g));
      end
      @(posedge clk); #1;
      RVALID = 1'b0; RLAST = 1'b0;
      $display("fairness grant %0d -> master %0d", k, g);
    end
    m_arvalid = '0; m_rready = '0;
  endtask

  task automatic test_ar_stall();
    @(posedge clk); #1;
    m_arvalid[5] = 1'b1; m_arlen[5*4 +: 4] = 4'd2; m_araddr[5*AW +: AW] = 26'h155_AA0;
    ARREADY = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_arready !== N'(1 << 5)) begin
      n_fail++; $display("FAIL stall_accept: m_arready=%b expected %b", m_arready, N'(1 << 5));
    end
    @(posedge clk); #1;
    m_arvalid[5] = 1'b0; m_arvalid[0] = 1'b1; m_arvalid[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (ARVALID !== 1'b1 || ARID !== 4'd5 || ARLEN !== 4'd2 || ARADDR !== 26'h155_AA0 || m_arready !== '0) begin
        n_fail++;
        $display("FAIL stall_cycle_%0d: ARVALID=%b ARID=%0d ARLEN=%0d ARADDR=%h m_arready=%b expected 1/5/2/155aa0/0",
                 c, ARVALID, ARID, ARLEN, ARADDR, m_arready);
      end
      @(posedge clk); #1;
    end
    ARREADY = 1'b1; m_arvalid = '0;
    run_beats(5, 2);
    $display("ar_stall burst complete");
  endtask

  task automatic test_rready_stall();
    issue_req(2, 4'd3, 26'h2C0);
    @(posedge clk); #1;
    RVALID = 1'b1; RID = 4'd2; RLAST = 1'b0; RDATA = 32'hD000_0000; m_rready[2] = 1'b1;
    @(posedge clk); #1;
    RDATA = 32'hD000_0001; m_rready[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (RREADY !== 1'b0 || m_rvalid !== N'(1 << 2) || m_rdata !== 32'hD000_0001) begin
        n_fail++;
        $display("FAIL rready_stall_%0d: RREADY=%b m_rvalid=%b m_rdata=%h expected 0/%b/d0000001",
                 c, RREADY, m_rvalid, m_rdata, N'(1 << 2));
      end
      @(posedge clk); #1;
    end
    m_rready[2] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (RREADY !== 1'b1) begin
      n_fail++; $display("FAIL rready_resume: RREADY=%b expected 1", RREADY);
    end
    @(posedge clk); #1 RDATA = 32'hD000_0002;
    @(posedge clk); #1 RDATA = 32'hD000_0003; RLAST = 1'b1;
    @(posedge clk); #1 RVALID = 1'b0; RLAST = 1'b0; m_rready = '0;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || ARVALID !== 1'b0) begin
      n_fail++; $display("FAIL rready_stall_end: err=%b ARVALID=%b expected 0/0", err, ARVALID);
    end
    $display("rready_stall burst complete");
  endtask

  task automatic test_errors();
    issue_req(2, 4'd1, 26'h300);
    @(posedge clk); #1;
    RVALID = 1'b1; RID = 4'd5; RLAST = 1'b0; RDATA = 32'hBAD0_0005; m_rready[2] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (RREADY !== 1'b0 || m_rvalid !== '0 || err !== 1'b0) begin
      n_fail++; $display("FAIL wrong_rid_route: RREADY=%b m_rvalid=%b err=%b expected 0/0/0", RREADY, m_rvalid, err);
    end
    @(posedge clk); #1 RID = 4'd2;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || RREADY !== 1'b1) begin
      n_fail++; $display("FAIL wrong_rid_err: err=%b RREADY=%b expected 1/1", err, RREADY);
    end
    @(posedge clk); #1 RLAST = 1'b1;
    @(posedge clk); #1 RVALID = 1'b0; RLAST = 1'b0; m_rready = '0;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || ARVALID !== 1'b0) begin
      n_fail++; $display("FAIL err_sticky: err=%b ARVALID=%b expected 1/0", err, ARVALID);
    end
    $display("wrong_rid scenario complete");

    do_reset();
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_cleared: err=%b expected 0", err);
    end
    issue_req(2, 4'd3, 26'h340);
    @(posedge clk); #1;
    RVALID = 1'b1; RID = 4'd2; RLAST = 1'b0; m_rready[2] = 1'b1;
    @(posedge clk); #1 RLAST = 1'b1;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL early_rlast_pre: err=%b expected 0", err);
    end
    @(posedge clk); #1;
    RVALID = 1'b0; RLAST = 1'b0; m_rready = '0; m_arvalid[6] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || m_arready !== N'(1 << 6)) begin
      n_fail++;
      $display("FAIL early_rlast: err=%b m_arready=%b expected 1/%b", err, m_arready, N'(1 << 6));
    end
    do_reset();
    $display("early_rlast scenario complete");
  endtask

  task automatic test_reset_mid_burst();
    issue_req(6, 4'd2, 26'h3F0);
    @(posedge clk); #1;
    RVALID = 1'b1; RID = 4'd6; RLAST = 1'b0; m_rready[6] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_rvalid !== N'(1 << 6)) begin
      n_fail++; $display("FAIL mid_burst_route: m_rvalid=%b expected %b", m_rvalid, N'(1 << 6));
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_rvalid !== '0 || RREADY !== 1'b0 || ARVALID !== 1'b0 || m_arready !== '0 ||
        ARID !== 4'd0 || ARLEN !== 4'd0 || ARADDR !== '0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: m_rvalid=%b RREADY=%b ARVALID=%b m_arready=%b ARID=%0d ARLEN=%0d ARADDR=%h err=%b expected all 0",
               m_rvalid, RREADY, ARVALID, m_arready, ARID, ARLEN, ARADDR, err);
    end
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;
    m_arvalid[0] = 1'b1; m_arvalid[4] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_arready !== N'(1 << 0)) begin
      n_fail++; $display("FAIL post_reset_grant: m_arready=%b expected %b", m_arready, N'(1 << 0));
    end
    do_reset();
    $display("reset_mid_burst scenario complete");
  endtask

`ifdef ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    m_arlen[0 +: 4] = 4'd0; m_arlen[4 +: 4] = 4'd0;
    m_arvalid[0] = 1'b1; m_arvalid[1] = 1'b1; m_rready = '1; ARREADY = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_arready !== N'(1)) begin
      n_fail++; $display("FAIL perf_first_grant: m_arready=%b expected %b", m_arready, N'(1));
    end
    @(posedge clk); #1 m_arvalid[0] = 1'b0;
    @(posedge clk); #1 RVALID = 1'b1; RID = 4'd0; RLAST = 1'b1;
    @(posedge clk); #1 RVALID = 1'b0; RLAST = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_arready !== N'(2)) begin
      n_fail++; $display("FAIL perf_second_grant: m_arready=%b expected %b", m_arready, N'(2));
    end
    @(posedge clk); #1 m_arvalid[1] = 1'b0;
    @(posedge clk); #1 RVALID = 1'b1; RID = 4'd1; RLAST = 1'b1;
    @(posedge clk); #1 RVALID = 1'b0; RLAST = 1'b0; m_rready = '0;
    @(negedge clk);
    n_checks++;
    if (perf_grant_cnt[0 +: 32] !== 32'd1 || perf_grant_cnt[32 +: 32] !== 32'd1 ||
        perf_wait_cnt[0 +: 32] !== 32'd0 || perf_wait_cnt[32 +: 32] !== 32'd3) begin
      n_fail++;
      $display("FAIL perf_counts: grant0=%0d grant1=%0d wait0=%0d wait1=%0d expected 1/1/0/3",
               perf_grant_cnt[0 +: 32], perf_grant_cnt[32 +: 32], perf_wait_cnt[0 +: 32], perf_wait_cnt[32 +: 32]);
    end
    $display("perf scenario complete");
  endtask
`endif

  initial begin
    test_reset();
    test_single_master();
    test_fairness();
    test_ar_stall();
    test_rready_stall();
    test_errors();
    test_reset_mid_burst();
`ifdef ARB_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
